// File: rtl/morse_sched_pkg.sv
// Shared types and scancode constants for the Morse character scheduler.
package morse_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDispatch,
        StWaitAck,
        StWaitDone,
        StGap
    } sched_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Controller replies and error codes that never reach the encoder.
    function automatic logic is_discard(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Synchronous FIFO with occupancy count; a pop on the same cycle lets a push into a full FIFO through.
module morse_char_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/morse_char_scheduler.sv
// Filters PS/2 scancodes to make codes, queues them and hands one character at a time
// to the Morse encoder, leaving a programmable gap after each one.
module morse_char_scheduler
    import morse_sched_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             ps2_received_data,
    input  logic                   ps2_received_data_strb,
    input  logic                   encoder_busy,
    output logic [7:0]             char_data,
    output logic                   char_strb,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    sched_state_e    state_q, state_d;
    logic            brk_pend_q, brk_pend_d;
    logic            ext_pend_q, ext_pend_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      char_data_q, char_data_d;
    logic            char_strb_q, char_strb_d;
    logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            push, pop;
    logic [7:0]      fifo_rdata;
    logic            fifo_full, fifo_empty;

    // Prefix bytes arm a one-shot discard of the following non-prefix byte.
    always_comb begin
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        push       = 1'b0;
        if (ps2_received_data_strb) begin
            if (ps2_received_data == PS2_BREAK) begin
                brk_pend_d = 1'b1;
            end else if (ps2_received_data == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (brk_pend_q || ext_pend_q) begin
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
            end else if (!is_discard(ps2_received_data)) begin
                push = 1'b1;
            end
        end
    end

    assign overflow_d = overflow_q | (push & fifo_full & ~pop);

    morse_char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (ps2_received_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        char_data_d = char_data_q;
        ack_cnt_d   = ack_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Head is latched on entry so it is stable for the whole strobe cycle.
                if (!fifo_empty) begin
                    state_d     = StDispatch;
                    char_data_d = fifo_rdata;
                end
            end
            StDispatch: begin
                pop       = 1'b1;
                ack_cnt_d = '0;
                state_d   = StWaitAck;
            end
            StWaitAck: begin
                if (encoder_busy) begin
                    state_d = StWaitDone;
                end else if (ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!encoder_busy) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        char_strb_d = (state_d == StDispatch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            char_data_q <= 8'h00;
            char_strb_q <= 1'b0;
            ack_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            brk_pend_q  <= brk_pend_d;
            ext_pend_q  <= ext_pend_d;
            overflow_q  <= overflow_d;
            char_data_q <= char_data_d;
            char_strb_q <= char_strb_d;
            ack_cnt_q   <= ack_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign char_data = char_data_q;
    assign char_strb = char_strb_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_morse_char_scheduler.sv
// Directed bench for morse_char_scheduler: filtering, queueing, gap timing, timeout and reset.
module tb_morse_char_scheduler;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 16;
    localparam int unsigned ACK   = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_strb = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] char_data;
    logic       char_strb;
    logic [3:0] fifo_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int max_cnt = 0;
    logic [7:0] disp_q [$];
    int         disp_cyc [$];

    morse_char_scheduler #(
        .DEPTH       (DEPTH),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ps2_received_data      (ps2_data),
        .ps2_received_data_strb (ps2_strb),
        .encoder_busy           (busy),
        .char_data              (char_data),
        .char_strb              (char_strb),
        .fifo_count             (fifo_count),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (char_strb) begin
            disp_q.push_back(char_data);
            disp_cyc.push_back(cyc);
        end
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_data = b;
        ps2_strb = 1'b1;
        tick();
        ps2_strb = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        busy     = 1'b0;
        ps2_strb = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        disp_q.delete();
        disp_cyc.delete();
        max_cnt = 0;
    endtask

    task automatic wait_disp(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (disp_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (disp_q.size() >= n);
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (char_data !== 8'h00) begin
            errors++; $display("FAIL reset_char_data: got %0h want 00", char_data);
        end
        checks++;
        if (char_strb !== 1'b0) begin
            errors++; $display("FAIL reset_char_strb: got %0b want 0", char_strb);
        end
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %0b want 0", overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_and_gap();
        bit ok;
        int t0;
        do_reset();
        send(8'h1C);
        checks++;
        if (fifo_count !== 4'd1) begin
            errors++; $display("FAIL push_latency: got %0d want 1", fifo_count);
        end
        tick();
        checks++;
        if (char_strb !== 1'b1) begin
            errors++; $display("FAIL dispatch_latency: got %0b want 1", char_strb);
        end
        checks++;
        if (char_data !== 8'h1C) begin
            errors++; $display("FAIL dispatch_data: got %0h want 1c", char_data);
        end
        busy = 1'b1;
        send(8'h32);
        repeat (99) tick();
        checks++;
        if (disp_q.size() != 1) begin
            errors++; $display("FAIL single_busy_hold: got %0d dispatches want 1", disp_q.size());
        end
        busy = 1'b0;
        t0 = cyc;
        wait_disp(2, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL gap_dispatch: got %0d dispatches want 2", disp_q.size());
        end else begin
            checks++;
            if (disp_q[1] !== 8'h32) begin
                errors++; $display("FAIL gap_data: got %0h want 32", disp_q[1]);
            end
            checks++;
            if (disp_cyc[1] - t0 < int'(GAP) + 1) begin
                errors++;
                $display("FAIL gap_spacing: got %0d want >= %0d", disp_cyc[1] - t0, GAP + 1);
            end
        end
    endtask

    task automatic test_filter();
        bit ok;
        logic [7:0] seq [10] = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75,
                                 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'h32};
        do_reset();
        for (int i = 0; i < 10; i++) send(seq[i]);
        wait_disp(2, 300, ok);
        repeat (120) tick();
        checks++;
        if (disp_q.size() != 2) begin
            errors++; $display("FAIL filter_count: got %0d dispatches want 2", disp_q.size());
        end
        if (ok) begin
            checks++;
            if (disp_q[0] !== 8'h1C) begin
                errors++; $display("FAIL filter_first: got %0h want 1c", disp_q[0]);
            end
            checks++;
            if (disp_q[1] !== 8'h32) begin
                errors++; $display("FAIL filter_second: got %0h want 32", disp_q[1]);
            end
        end
        checks++;
        if (max_cnt != 1) begin
            errors++; $display("FAIL filter_max_count: got %0d want 1", max_cnt);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] codes [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                                   8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 10; i++) send(codes[i]);
        checks++;
        if (fifo_count !== 4'd8) begin
            errors++; $display("FAIL ovf_count: got %0d want 8", fifo_count);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_flag: got %0b want 1", overflow);
        end
        busy = 1'b0;
        wait_disp(9, 1500, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ovf_drain: got %0d dispatches want 9", disp_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (disp_q[i] !== codes[i]) begin
                    errors++; $display("FAIL ovf_order[%0d]: got %0h want %0h", i, disp_q[i], codes[i]);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        send(8'h1C);
        send(8'h32);
        wait_disp(2, 200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL timeout_dispatch: got %0d dispatches want 2", disp_q.size());
        end else begin
            checks++;
            if (disp_cyc[1] - disp_cyc[0] != int'(ACK + GAP) + 2) begin
                errors++;
                $display("FAIL timeout_spacing: got %0d want %0d",
                         disp_cyc[1] - disp_cyc[0], ACK + GAP + 2);
            end
            checks++;
            if (disp_q[1] !== 8'h32) begin
                errors++; $display("FAIL timeout_data: got %0h want 32", disp_q[1]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL timeout_overflow: got %0b want 0", overflow);
        end
    endtask

    task automatic test_full_push_on_dispatch();
        int k;
        logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                                  8'h35, 8'h3C, 8'h43, 8'h44};
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 9; i++) send(codes[i]);
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_setup: got count=%0d ovf=%0b want count=8 ovf=0",
                     fifo_count, overflow);
        end
        busy = 1'b0;
        k = 0;
        while (!char_strb && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (char_strb !== 1'b1) begin
            errors++; $display("FAIL full_dispatch: got strb=%0b want 1", char_strb);
        end else begin
            checks++;
            if (char_data !== 8'h1D) begin
                errors++; $display("FAIL full_head: got %0h want 1d", char_data);
            end
            send(8'h4D);
            checks++;
            if (fifo_count !== 4'd8) begin
                errors++; $display("FAIL full_push_count: got %0d want 8", fifo_count);
            end
            checks++;
            if (overflow !== 1'b0) begin
                errors++; $display("FAIL full_push_overflow: got %0b want 0", overflow);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        busy = 1'b1;
        send(8'h1C);
        send(8'h32);
        send(8'h2C);
        send(8'h15);
        tick();
        tick();
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++; $display("FAIL mid_queued: got %0d want 3", fifo_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (char_data !== 8'h00 || char_strb !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out: got data=%0h strb=%0b want 00/0", char_data, char_strb);
        end
        checks++;
        if (fifo_count !== 4'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_fifo: got count=%0d ovf=%0b want 0/0", fifo_count, overflow);
        end
        tick();
        rst  = 1'b0;
        busy = 1'b0;
        disp_q.delete();
        disp_cyc.delete();
        repeat (120) tick();
        checks++;
        if (disp_q.size() != 0) begin
            errors++; $display("FAIL mid_no_dispatch: got %0d dispatches want 0", disp_q.size());
        end
        send(8'h2C);
        tick();
        checks++;
        if (char_strb !== 1'b1 || char_data !== 8'h2C) begin
            errors++;
            $display("FAIL mid_new_char: got strb=%0b data=%0h want 1/2c", char_strb, char_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_and_gap();
        test_filter();
        test_overflow();
        test_timeout();
        test_full_push_on_dispatch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_char_scheduler.md
# morse_char_scheduler

Sits between `ps2_controller` and `morse_code_encoder`. Filters the raw PS/2 scancode stream down to make codes, buffers them in a small FIFO, and dispatches one character at a time to the encoder. A new character goes out only after the encoder has finished the previous one and a programmable inter-character gap has elapsed. Fast typing no longer overwrites a character that is still being keyed.

## Interface
Parameters:
- `DEPTH`, 8, FIFO entries; power of two, 2..32.
- `GAP_CYCLES`, 16, idle cycles enforced after encoder busy falls before the next dispatch; minimum 1.
- `ACK_TIMEOUT`, 64, cycles to wait for encoder busy to rise after a dispatch before giving up.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `ps2_received_data` in 8: scancode byte from the PS/2 controller.
- `ps2_received_data_strb` in 1: one-cycle valid for `ps2_received_data`.
- `encoder_busy` in 1: high while the encoder is keying a character.
- `char_data` out 8: make code presented to the encoder; registered.
- `char_strb` out 1: one-cycle dispatch strobe.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; set when an accepted make code is dropped because the FIFO is full.

## Operation
Filter (runs on every `ps2_received_data_strb`):
- Byte `0xF0` sets `brk_pend`. Byte `0xE0` sets `ext_pend`. Neither byte is stored.
- If `brk_pend` or `ext_pend` is set, the next byte that is not `0xF0`/`0xE0` is discarded and both flags clear. This drops `E0 xx`, `F0 xx` and `E0 F0 xx` completely.
- Bytes `0x00`, `0xAA`, `0xFA`, `0xFE` and `0xFF` are always discarded.
- Every other byte is a make code and is pushed into the FIFO.
- Push into a full FIFO: the byte is dropped and `overflow` is set. Exception: a pop happens in the same cycle, so the push succeeds.

Scheduler FSM:
- IDLE: when the FIFO is not empty, go to DISPATCH.
- DISPATCH: one cycle. `char_strb`=1, and `char_data` is loaded with the FIFO head, which is popped. Next state is WAIT_ACK.
- WAIT_ACK: when `encoder_busy`=1, go to WAIT_DONE. When `ACK_TIMEOUT` cycles elapse first, go to GAP; the character is considered consumed and is not retried.
- WAIT_DONE: when `encoder_busy`=0, go to GAP.
- GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- `char_data` holds its value from one dispatch until the next one.

## Timing
- Reset values: `char_data`=0x00, `char_strb`=0, `fifo_count`=0, `overflow`=0, state IDLE, pointers 0, `brk_pend`=`ext_pend`=0, counters 0.
- Reset mid-operation clears all of the above immediately. Buffered characters are lost.
- Push latency: a make code sampled with strobe at edge k appears in `fifo_count` after edge k.
- Dispatch latency, empty FIFO and IDLE: `char_strb` is high during the cycle after edge k+1, i.e. 2 cycles after the strobe.
- Back-to-back dispatch spacing: at least 1 (DISPATCH) + 1 (WAIT_ACK) + busy duration + `GAP_CYCLES` + 1 (IDLE) cycles.
- Simultaneous push and pop: `fifo_count` is unchanged and the order of entries is preserved.
- Pointers wrap modulo `DEPTH`. Full is `fifo_count`==`DEPTH`.
- `encoder_busy` already high in DISPATCH: WAIT_ACK exits on the next edge.
- `encoder_busy` is assumed synchronous to `clk`.

## Structure
- Package `morse_sched_pkg` holds:
  - the state enum: IDLE, DISPATCH, WAIT_ACK, WAIT_DONE, GAP;
  - the prefix constants: `PS2_BREAK`=0xF0, `PS2_EXT`=0xE0;
  - the discard list.
- Sub-module `morse_char_fifo`: synchronous FIFO with push, pop, data in/out, count and full/empty. It has no knowledge of scancodes.
- Filter, FSM, timeout counter and gap counter live in `morse_char_scheduler`.

## Test plan
- Push `1C` with the encoder idle → `char_strb` 2 cycles later, `char_data`=0x1C; drive busy for 100 cycles → the next dispatch occurs no earlier than `GAP_CYCLES`+1 cycles after busy falls.
- Send `1C F0 1C E0 75 E0 F0 75 AA 32` → exactly two dispatches, 0x1C then 0x32; `fifo_count` never exceeds 1.
- Hold busy high; push 10 make codes with `DEPTH`=8 → `fifo_count`=8 and `overflow`=1; after release, 8 dispatches in push order.
- Never assert busy after a dispatch → return to IDLE after `ACK_TIMEOUT`+`GAP_CYCLES` cycles, the next queued character dispatches, and `overflow` is unaffected.
- Full FIFO with a push on the same cycle as DISPATCH → push accepted, `overflow` stays 0, `fifo_count` stays 8.
- Assert `rst` during WAIT_DONE with 3 entries queued → all outputs return to reset values immediately, and no dispatch occurs after release until a new make code arrives.
